// File: rtl/bfp_pkg.sv
// Shared definitions for the bf16 -> block-floating-point sequencer slice.
package bfp_pkg;

    // bf16 lane layout: {sign, exponent[7:0], fraction[6:0]}
    localparam int unsigned BF16_W        = 16;
    localparam int unsigned BF16_SIGN_BIT = 15;
    localparam int unsigned BF16_EXP_LSB  = 7;
    localparam int unsigned BF16_FRAC_W   = 7;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } seq_state_e;

    // Pipeline depth of bf16_to_bfp_core: max-exponent tree depth by lane-count band,
    // plus the shift/round stages for the mantissa width.
    function automatic int unsigned core_latency(input int unsigned num,
                                                 input int unsigned exp_w,
                                                 input int unsigned mant_w);
        int unsigned max_lat;
        if (exp_w == 0) return 0;  // no exponent field means no core
        if (num <= 4)        max_lat = 2;
        else if (num <= 12)  max_lat = 4;
        else if (num <= 36)  max_lat = 6;
        else if (num <= 108) max_lat = 8;
        else                 max_lat = 10;
        return max_lat + (($clog2(mant_w) + 1) / 2) + 2;
    endfunction

endpackage

// File: rtl/bfp_block_sequencer_fifo.sv
// Synchronous output FIFO holding {shared exponent, mantissas, last} per block.
module bfp_out_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CntW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still legal when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PtrW'(DEPTH - 1)) ? '0 : wr_ptr + PtrW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(DEPTH - 1)) ? '0 : rd_ptr + PtrW'(1);
            if (do_push && !do_pop)      cnt <= cnt + CntW'(1);
            else if (!do_push && do_pop) cnt <= cnt - CntW'(1);
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bfp_block_sequencer.sv
// Frames bf16 blocks into a fixed-latency BFP core and buffers results with credit flow control.
module bfp_block_sequencer
    import bfp_pkg::*;
#(
    parameter int unsigned NUM          = 10,
    parameter int unsigned EXP_W        = 8,
    parameter int unsigned MANT_W       = 8,
    parameter int unsigned CORE_LATENCY = core_latency(NUM, EXP_W, MANT_W),
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned NX_MODE      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             num_blocks,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM*BF16_W-1:0]   in_data,
    output logic [NUM-1:0]          core_sign,
    output logic [NUM*EXP_W-1:0]    core_exp,
    output logic [NUM*MANT_W-1:0]   core_mant,
    input  logic [EXP_W-1:0]        core_shared_exp,
    input  logic [NUM*MANT_W-1:0]   core_sdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W-1:0]        out_exp,
    output logic [NUM*MANT_W-1:0]   out_data,
    output logic                    out_last
);

    localparam int unsigned DataW = EXP_W + NUM * MANT_W + 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < CORE_LATENCY + 2) begin : g_depth_check
        $error("FIFO_DEPTH must be at least CORE_LATENCY+2");
    end
    if (NX_MODE > 1) begin : g_nx_check
        $error("NX_MODE must be 0 or 1");
    end

    seq_state_e                 state;
    logic [15:0]                num_q;
    logic [15:0]                blk_in;
    logic [CORE_LATENCY:0]      vld_pipe;
    logic [CORE_LATENCY:0]      last_pipe;
    logic [CntW-1:0]            inflight;
    logic [CntW-1:0]            fifo_count;
    logic [CntW:0]              credit_used;
    logic                       fifo_empty;
    logic [DataW-1:0]           fifo_rdata;
    logic                       accept;
    logic                       last_in;
    logic                       push;
    logic                       pop;
    logic [NUM-1:0]             sign_n;
    logic [NUM*EXP_W-1:0]       exp_n;
    logic [NUM*MANT_W-1:0]      mant_n;

    // Every block admitted must already own a FIFO slot, since the core cannot stall.
    assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    assign in_ready    = (state == StRun) && (credit_used < (CntW + 1)'(FIFO_DEPTH));
    assign accept      = in_valid && in_ready;
    assign last_in     = (blk_in == num_q - 16'd1);
    assign push        = vld_pipe[CORE_LATENCY];
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    assign {out_exp, out_data, out_last} = fifo_rdata;

    // Split each bf16 lane into sign, exponent and mantissa with the implicit leading one.
    always_comb begin
        sign_n = '0;
        exp_n  = '0;
        mant_n = '0;
        for (int i = 0; i < NUM; i++) begin
            sign_n[i]                    = in_data[BF16_W*i + BF16_SIGN_BIT];
            exp_n[EXP_W*i +: EXP_W]      = in_data[BF16_W*i + BF16_EXP_LSB +: EXP_W];
            // Zero and denormal lanes carry no hidden bit.
            mant_n[MANT_W*i +: MANT_W]   = MANT_W'({(in_data[BF16_W*i + BF16_EXP_LSB +: EXP_W] != '0),
                                                    in_data[BF16_W*i +: BF16_FRAC_W]});
        end
    end

    // Core input registers, loaded only on an accepted block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_sign <= '0;
            core_exp  <= '0;
            core_mant <= '0;
        end else if (accept) begin
            core_sign <= sign_n;
            core_exp  <= exp_n;
            core_mant <= mant_n;
        end
    end

    // Track which core slots hold a real block, and how many are in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            inflight  <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[CORE_LATENCY-1:0], accept};
            last_pipe <= {last_pipe[CORE_LATENCY-1:0], accept && last_in};
            if (accept && !push)      inflight <= inflight + CntW'(1);
            else if (!accept && push) inflight <= inflight - CntW'(1);
        end
    end

    // Message framing FSM with registered busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            busy   <= 1'b0;
            done   <= 1'b0;
            num_q  <= '0;
            blk_in <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (num_blocks == '0) begin
                            done <= 1'b1;
                        end else begin
                            state  <= StRun;
                            busy   <= 1'b1;
                            num_q  <= num_blocks;
                            blk_in <= '0;
                        end
                    end
                end
                StRun: begin
                    if (accept) begin
                        blk_in <= blk_in + 16'd1;
                        if (last_in) state <= StDrain;
                    end
                end
                StDrain: begin
                    if (pop && out_last) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    bfp_out_fifo #(
        .WIDTH (DataW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({core_shared_exp, core_sdata, last_pipe[CORE_LATENCY]}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_bfp_block_sequencer.sv
// Directed and randomized bench for bfp_block_sequencer with a stand-in core and block scoreboard.
module tb_bfp_block_sequencer;

    localparam int unsigned NUM    = 10;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 8;
    localparam int unsigned L      = 8;
    localparam int unsigned D      = 16;
    localparam int unsigned BW     = EXP_W + NUM * MANT_W;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [15:0]            num_blocks = '0;
    logic                   busy, done;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [NUM*16-1:0]      in_data = '0;
    logic [NUM-1:0]         core_sign;
    logic [NUM*EXP_W-1:0]   core_exp;
    logic [NUM*MANT_W-1:0]  core_mant;
    logic [EXP_W-1:0]       core_shared_exp;
    logic [NUM*MANT_W-1:0]  core_sdata;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [EXP_W-1:0]       out_exp;
    logic [NUM*MANT_W-1:0]  out_data;
    logic                   out_last;

    always #5 clk = ~clk;

    bfp_block_sequencer #(
        .NUM          (NUM),
        .EXP_W        (EXP_W),
        .MANT_W       (MANT_W),
        .CORE_LATENCY (L),
        .FIFO_DEPTH   (D),
        .NX_MODE      (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_blocks      (num_blocks),
        .busy            (busy),
        .done            (done),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .core_sign       (core_sign),
        .core_exp        (core_exp),
        .core_mant       (core_mant),
        .core_shared_exp (core_shared_exp),
        .core_sdata      (core_sdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_exp         (out_exp),
        .out_data        (out_data),
        .out_last        (out_last)
    );

    // Stand-in core: shared exponent = max lane exponent, mantissa negated for negative lanes.
    function automatic logic [BW-1:0] core_fn(input logic [NUM-1:0] s,
                                              input logic [NUM*EXP_W-1:0] e,
                                              input logic [NUM*MANT_W-1:0] m);
        logic [EXP_W-1:0]      se;
        logic [NUM*MANT_W-1:0] sd;
        logic [MANT_W-1:0]     lm;
        se = '0;
        sd = '0;
        for (int i = 0; i < NUM; i++) begin
            if (e[EXP_W*i +: EXP_W] > se) se = e[EXP_W*i +: EXP_W];
            lm = m[MANT_W*i +: MANT_W];
            sd[MANT_W*i +: MANT_W] = s[i] ? -lm : lm;
        end
        return {se, sd};
    endfunction

    // Expected core result straight from the raw bf16 lanes.
    function automatic logic [BW-1:0] ref_block(input logic [NUM*16-1:0] d);
        logic [NUM-1:0]        s;
        logic [NUM*EXP_W-1:0]  e;
        logic [NUM*MANT_W-1:0] m;
        for (int i = 0; i < NUM; i++) begin
            s[i]          = d[16*i + 15];
            e[8*i +: 8]   = d[16*i + 7 +: 8];
            m[8*i +: 8]   = {(d[16*i + 7 +: 8] != 8'd0), d[16*i +: 7]};
        end
        return core_fn(s, e, m);
    endfunction

    // Core with L cycles between registered input and output.
    logic [BW-1:0] core_pipe [L];
    always @(posedge clk) begin
        core_pipe[0] <= core_fn(core_sign, core_exp, core_mant);
        for (int i = 1; i < L; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign {core_shared_exp, core_sdata} = core_pipe[L-1];

    typedef struct {
        logic [BW-1:0] blk;
        logic          last;
        int            cyc;
    } sb_t;

    sb_t sb[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  n_pop = 0;
    int  n_done = 0;
    int  msg_nb = 0;
    int  msg_acc = 0;
    bit  chk_lat = 1'b0;
    int  start_cyc;
    int  done_before;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < NUM; i++) begin
            in_data[16*i +: 16] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) in_data[16*i + 7 +: 8] = 8'h00;
        end
    endtask

    // One clock: observe handshakes at the falling edge, then return just after the rising edge.
    task automatic cycle();
        sb_t e;
        @(negedge clk);
        cyc++;
        if (in_valid && in_ready) begin
            e.blk  = ref_block(in_data);
            e.last = (msg_acc == msg_nb - 1);
            e.cyc  = cyc;
            sb.push_back(e);
            msg_acc++;
        end
        if (out_valid && out_ready) begin
            n_pop++;
            n_chk++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL pop_has_entry: observed pop with empty scoreboard, required none");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_exp", 128'(out_exp), 128'(e.blk[BW-1 -: EXP_W]));
                check("out_data", 128'(out_data), 128'(e.blk[NUM*MANT_W-1:0]));
                check("out_last", 128'(out_last), 128'(e.last));
                if (chk_lat) check("latency", 128'(cyc - e.cyc), 128'(L + 2));
            end
        end
        if (done) n_done++;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_msg(input int nb);
        msg_nb     = nb;
        msg_acc    = 0;
        n_pop      = 0;
        num_blocks = 16'(nb);
        start      = 1'b1;
        cycle();
        start      = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        rst = 1'b0;
        cycle();

        // Four back-to-back blocks with free-flowing output
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rand_data();
        chk_lat   = 1'b1;
        begin_msg(4);
        start_cyc = cyc;
        for (int i = 0; i < 200 && n_pop < 4; i++) begin
            rand_data();
            cycle();
        end
        chk_lat = 1'b0;
        check("t1_pops", 128'(n_pop), 128'(4));
        check("t1_b2b_span", 128'(cyc - start_cyc), 128'(4 + L + 2));
        check("t1_done", 128'(done), 128'(1));
        check("t1_busy_fall", 128'(busy), 128'(0));
        cycle();
        check("t1_done_pulse", 128'(done), 128'(0));

        // Backpressure: credit limits acceptance to the FIFO depth
        out_ready = 1'b0;
        in_valid  = 1'b1;
        begin_msg(100);
        for (int i = 0; i < 40; i++) begin
            rand_data();
            cycle();
        end
        check("t2_accepts", 128'(msg_acc), 128'(D));
        check("t2_in_ready_low", 128'(in_ready), 128'(0));
        check("t2_out_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 2000 && n_pop < 100; i++) begin
            rand_data();
            cycle();
        end
        check("t2_pops", 128'(n_pop), 128'(100));
        check("t2_done", 128'(done), 128'(1));
        cycle();

        // Lane unpack of 1.0, -2.0 and zero
        in_valid = 1'b1;
        rand_data();
        in_data[15:0]  = 16'h3F80;
        in_data[31:16] = 16'hC000;
        in_data[47:32] = 16'h0000;
        begin_msg(1);
        cycle();
        in_valid = 1'b0;
        check("t3_exp", 128'(core_exp[23:0]), 128'(24'h00807F));
        check("t3_mant", 128'(core_mant[23:0]), 128'(24'h008080));
        check("t3_sign", 128'(core_sign[2:0]), 128'(3'b010));
        for (int i = 0; i < 100 && n_pop < 1; i++) cycle();
        check("t3_pops", 128'(n_pop), 128'(1));
        cycle();

        // Zero-length message
        in_valid = 1'b1;
        begin_msg(0);
        check("t4_done", 128'(done), 128'(1));
        check("t4_busy", 128'(busy), 128'(0));
        check("t4_in_ready", 128'(in_ready), 128'(0));
        cycle();
        check("t4_done_pulse", 128'(done), 128'(0));
        check("t4_no_accept", 128'(msg_acc), 128'(0));

        // Reset while draining three queued blocks
        out_ready = 1'b0;
        begin_msg(3);
        for (int i = 0; i < 20; i++) begin
            rand_data();
            cycle();
        end
        check("t5_accepts", 128'(msg_acc), 128'(3));
        check("t5_drain_busy", 128'(busy), 128'(1));
        check("t5_queued", 128'(out_valid), 128'(1));
        done_before = n_done;
        rst = 1'b1;
        #1;
        check("t5_rst_out_valid", 128'(out_valid), 128'(0));
        check("t5_rst_busy", 128'(busy), 128'(0));
        sb.delete();
        cycle();
        cycle();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
        check("t5_no_done", 128'(n_done - done_before), 128'(0));
        check("t5_still_empty", 128'(out_valid), 128'(0));
        begin_msg(2);
        for (int i = 0; i < 100 && n_pop < 2; i++) begin
            rand_data();
            cycle();
        end
        check("t5_next_pops", 128'(n_pop), 128'(2));
        check("t5_next_done", 128'(done), 128'(1));
        cycle();

        // Random valid/ready over a 1000-block message
        done_before = n_done;
        rand_data();
        begin_msg(1000);
        for (int i = 0; i < 20000 && n_pop < 1000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rand_data();
            cycle();
        end
        in_valid = 1'b0;
        check("t6_pops", 128'(n_pop), 128'(1000));
        check("t6_done", 128'(done), 128'(1));
        cycle();
        cycle();
        check("t6_single_done", 128'(n_done - done_before), 128'(1));
        check("t6_sb_empty", 128'(sb.size()), 128'(0));
        check("t6_idle", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
